fpu_in_responder: RTL and testbench
===================================

# fpu_in_responder

Synthesizable DUT-side end of the FPU_in handshake. It accepts one command (start, op, rmode, a, b) on the FPU_in bus and forwards legal operations to an execution core over a request/grant/done port. It returns the result with a one-cycle ready pulse. Illegal opcodes, overlapping starts and execution timeouts are answered with a canonical quiet NaN and recorded in sticky error flags. The bus side is what the FPU_in monitor observes: ready is held low until the result is valid.

## Interface
- FP_WIDTH, 32: operand/result width; only 32 or 64 are legal.
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before a forced NaN response; minimum 2.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- start  in  1  command strobe, sampled on the rising clk edge.
- op  in  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt; 5–7 are illegal.
- rmode  in  2  rounding mode; all values legal, passed through unchanged.
- a, b  in  FP_WIDTH  operands.
- ready  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  FP_WIDTH  registered result; holds its value until the next response.
- exec_req  out  1  request to the execution core.
- exec_op, exec_rmode, exec_a, exec_b  out  3/2/FP_WIDTH/FP_WIDTH  captured command; stable while exec_req is high.
- exec_gnt  in  1  core accepts the request.
- exec_done  in  1  core result valid.
- exec_result  in  FP_WIDTH  core result.
- err_illegal, err_overlap, err_timeout  out  1 each  sticky error flags.
- err_clr  in  1  synchronous clear of all sticky flags; a set event in the same cycle wins.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- QNAN: 0x7FC00000 when FP_WIDTH=32; 0x7FF8000000000000 when FP_WIDTH=64.
- IDLE, start=1:
  - Capture op, rmode, a and b into the exec_* registers.
  - If op<=4, go to REQ. Otherwise load result=QNAN, set err_illegal, go to RESP; the core is not contacted.
- REQ: exec_req=1. On exec_gnt:
  - exec_done=0: go to WAIT.
  - exec_done=1 in the same cycle: load result=exec_result, go to RESP.
- WAIT: exec_req=0. On exec_done, load result=exec_result and go to RESP.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without completion: result=QNAN, set err_timeout, exec_req drops, go to RESP.
  - exec_done in that same cycle wins over the timeout.
- RESP: ready=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back commands).
  - Otherwise go to IDLE.
- start=1 in REQ or WAIT: the command is dropped, err_overlap is set, and the in-flight operation is undisturbed.
- exec_done outside REQ/WAIT (for example a late done after a timeout) is ignored.
- Only one command is outstanding at a time.

## Timing
- Reset (asynchronous, rst=0):
  - state=IDLE; ready=0, result=0, exec_req=0; exec_* outputs=0.
  - All err_* flags=0; timeout counter=0.
- Reset mid-operation aborts the operation; no ready pulse is produced for it.
- Start is sampled at edge E0. Resulting ready timing:
  - Illegal op: ready high in the cycle after E0.
  - Legal op: exec_req high in the cycle after E0.
  - Legal op, gnt+done in the first REQ cycle: ready 2 cycles after E0 (minimum legal latency).
  - Done in WAIT: ready 1 cycle after the edge that samples exec_done.
  - Timeout: ready TIMEOUT+1 cycles after E0.
- All outputs are registered; there is no combinational path from bus inputs to ready or result.

## Test plan
- Reset, then start op=0, a=0x3F800000, b=0x40000000; core grants 1 cycle later and gives done with 0x40400000 3 cycles later -> exactly one ready pulse, result=0x40400000, exec_a/exec_b match the operands while exec_req is high.
- start with op=6 -> ready exactly 1 cycle later, result=0x7FC00000, err_illegal=1, exec_req never asserted. Then err_clr=1 -> err_illegal=0.
- TIMEOUT=8, core never sends done -> ready 9 cycles after start, result=QNAN, err_timeout=1. A late exec_done 2 cycles later causes no ready pulse.
- start pulses again 2 cycles into WAIT -> err_overlap=1; the original op completes with the core result and only one ready pulse is seen.
- start asserted in the RESP cycle with op=2 -> accepted, exec_req high on the next cycle, and two ready pulses in total.
- rst driven low asynchronously mid-WAIT -> ready, exec_req, result and flags go to 0 immediately. After release, a fresh op completes normally.

Source files
------------

// File: rtl/fpu_in_responder.sv
// rtl/fpu_in_responder.sv - DUT-side responder for the FPU_in command/result handshake
//
// Accepts one command at a time from the FPU_in bus, forwards legal opcodes to an
// execution core and returns the result with a one-cycle ready pulse. Illegal
// opcodes, overlapping starts and core timeouts answer with a canonical quiet NaN
// and set sticky error flags.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start/op/rmode/a/b        command strobe and payload from the bus
//   ready/result              response pulse and registered result
//   exec_req/exec_op/...      request and captured command toward the core
//   exec_gnt/exec_done        core accept and completion strobes
//   exec_result               core result, sampled on completion
//   err_illegal/overlap/tmo   sticky error flags; err_clr clears them
module fpu_in_responder #(
    parameter int FP_WIDTH = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [1:0]          rmode,
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    output logic                ready,
    output logic [FP_WIDTH-1:0] result,
    output logic                exec_req,
    output logic [2:0]          exec_op,
    output logic [1:0]          exec_rmode,
    output logic [FP_WIDTH-1:0] exec_a,
    output logic [FP_WIDTH-1:0] exec_b,
    input  logic                exec_gnt,
    input  logic                exec_done,
    input  logic [FP_WIDTH-1:0] exec_result,
    output logic                err_illegal,
    output logic                err_overlap,
    output logic                err_timeout,
    input  logic                err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [FP_WIDTH-1:0] QNAN = (FP_WIDTH == 64)
        ? FP_WIDTH'(64'h7FF8_0000_0000_0000)
        : FP_WIDTH'(32'h7FC0_0000);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FP_WIDTH-1:0]   result_q, result_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            rmode_q, rmode_d;
    logic [FP_WIDTH-1:0]   a_q, a_d;
    logic [FP_WIDTH-1:0]   b_q, b_d;
    logic                  ill_q, ill_d;
    logic                  ovl_q, ovl_d;
    logic                  tmo_q, tmo_d;

    logic accept;
    logic legal;
    logic busy;
    logic done_now;
    logic tmo_now;

    // RESP accepts a new command just like IDLE, giving back-to-back service.
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_RESP));
    assign legal    = (op <= 3'd4);
    assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign done_now = ((state_q == S_REQ) && exec_gnt && exec_done) ||
                      ((state_q == S_WAIT) && exec_done);
    // Completion in the final counted cycle takes priority over the timeout.
    assign tmo_now  = busy && !done_now && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            rmode_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ill_q    <= 1'b0;
            ovl_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_q     <= op_d;
            rmode_q  <= rmode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ill_q    <= ill_d;
            ovl_q    <= ovl_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) state_d = legal ? S_REQ : S_RESP;
                else        state_d = S_IDLE;
            end
            S_REQ: begin
                if (done_now || tmo_now) state_d = S_RESP;
                else if (exec_gnt)       state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_now || tmo_now) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        rmode_d  = rmode_q;
        a_d      = a_q;
        b_d      = b_q;

        if (accept) begin
            op_d    = op;
            rmode_d = rmode;
            a_d     = a;
            b_d     = b;
        end

        if (accept && legal) cnt_d = '0;
        else if (busy)       cnt_d = cnt_q + 1'b1;

        if (accept && !legal)  result_d = QNAN;
        else if (done_now)     result_d = exec_result;
        else if (tmo_now)      result_d = QNAN;

        // Clear first, then OR in set events so a same-cycle set survives.
        ill_d = (err_clr ? 1'b0 : ill_q) | (accept && !legal);
        ovl_d = (err_clr ? 1'b0 : ovl_q) | (start && busy);
        tmo_d = (err_clr ? 1'b0 : tmo_q) | tmo_now;
    end

    always_comb begin
        ready       = (state_q == S_RESP);
        exec_req    = (state_q == S_REQ);
        result      = result_q;
        exec_op     = op_q;
        exec_rmode  = rmode_q;
        exec_a      = a_q;
        exec_b      = b_q;
        err_illegal = ill_q;
        err_overlap = ovl_q;
        err_timeout = tmo_q;
    end

endmodule

// File: tb/tb_fpu_in_responder.sv
// tb/tb_fpu_in_responder.sv - randomized self-checking bench for fpu_in_responder
module tb_fpu_in_responder;

    localparam int W = 32;
    localparam int T = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [1:0]    rmode = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          exec_gnt = 1'b0;
    logic          exec_done = 1'b0;
    logic [W-1:0]  exec_result = '0;
    logic          err_clr = 1'b0;

    logic          ready;
    logic [W-1:0]  result;
    logic          exec_req;
    logic [2:0]    exec_op;
    logic [1:0]    exec_rmode;
    logic [W-1:0]  exec_a;
    logic [W-1:0]  exec_b;
    logic          err_illegal;
    logic          err_overlap;
    logic          err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ill = 1'b0;
    logic exp_ovl = 1'b0;
    logic exp_tmo = 1'b0;

    fpu_in_responder #(.FP_WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rmode(rmode), .a(a), .b(b),
        .ready(ready), .result(result), .exec_req(exec_req), .exec_op(exec_op),
        .exec_rmode(exec_rmode), .exec_a(exec_a), .exec_b(exec_b),
        .exec_gnt(exec_gnt), .exec_done(exec_done), .exec_result(exec_result),
        .err_illegal(err_illegal), .err_overlap(err_overlap), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ill"}, 64'(err_illegal), 64'(exp_ill));
        check({tag, "_ovl"}, 64'(err_overlap), 64'(exp_ovl));
        check({tag, "_tmo"}, 64'(err_timeout), 64'(exp_tmo));
    endtask

    // Core grants g cycles into REQ and completes d cycles after the grant
    // (d=0: same cycle). ovl_e is the edge index (after the accepting edge 0)
    // at which a second start is presented, or -1.
    task automatic run_cmd(input logic [2:0] op_i, input logic [W-1:0] a_i,
                           input logic [W-1:0] b_i, input logic [1:0] rm_i,
                           input int g, input int d, input logic [W-1:0] val,
                           input int ovl_e);
        int lat, req_exp, first_rdy, n_rdy, n_req;
        logic legal, completes, cmd_ok;
        logic [W-1:0] res_exp, res_seen;
        legal     = (op_i <= 3'd4);
        completes = legal && (1 + g + d <= T);
        if (!legal)         lat = 1;
        else if (completes) lat = g + d + 2;
        else                lat = T + 1;
        req_exp  = legal ? ((g + 1 < T) ? g + 1 : T) : 0;
        res_exp  = completes ? val : QNAN;
        res_seen = '0;

        start = 1'b1; op = op_i; a = a_i; b = b_i; rmode = rm_i; exec_result = val;
        first_rdy = -1; n_rdy = 0; n_req = 0; cmd_ok = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (ready) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    res_seen  = result;
                end
            end
            if (exec_req) begin
                n_req++;
                if (exec_a !== a_i || exec_b !== b_i || exec_op !== op_i || exec_rmode !== rm_i)
                    cmd_ok = 1'b0;
            end
            exec_gnt  = (k == g);
            exec_done = (k == g + d);
            start     = (k + 1 == ovl_e);
            if (start) begin
                op = op_i ^ 3'd1;
                a  = ~a_i;
            end
        end
        start = 1'b0; exec_gnt = 1'b0; exec_done = 1'b0;

        exp_ill = exp_ill | !legal;
        exp_ovl = exp_ovl | (ovl_e >= 0);
        exp_tmo = exp_tmo | (legal && !completes);

        check("ready_count", 64'(n_rdy), 64'd1);
        check("ready_latency", 64'(first_rdy + 1), 64'(lat));
        check("result_at_ready", 64'(res_seen), 64'(res_exp));
        check("result_hold", 64'(result), 64'(res_exp));
        check("req_cycles", 64'(n_req), 64'(req_exp));
        check("exec_cmd_stable", 64'(cmd_ok), 64'd1);
        check_flags("flags");
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ill = 1'b0; exp_ovl = 1'b0; exp_tmo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rdy, g, d, ovl_e, lat;
        logic [2:0] rop;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_exec_req", 64'(exec_req), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_exec_a", 64'(exec_a), 64'd0);
        check("rst_exec_op", 64'(exec_op), 64'd0);
        check_flags("rst");
        rst = 1'b1;
        @(negedge clk);

        // Basic add: grant one cycle in, done three cycles after grant
        run_cmd(3'd0, 32'h3F80_0000, 32'h4000_0000, 2'd0, 1, 3, 32'h4040_0000, -1);

        // Illegal opcode, then clear
        run_cmd(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 2'd1, 0, 0, 32'h0, -1);
        clear_errs();
        check_flags("after_clr");

        // Timeout with a late done two cycles after the forced response
        run_cmd(3'd0, 32'h1111_1111, 32'h2222_2222, 2'd2, 0, 10, 32'hDEAD_BEEF, -1);

        // Overlapping start two cycles into WAIT
        run_cmd(3'd1, 32'h4120_0000, 32'h3F80_0000, 2'd3, 0, 4, 32'h4110_0000, 3);

        // Clear and illegal start in the same cycle: the set wins
        err_clr = 1'b1; start = 1'b1; op = 3'd7;
        @(negedge clk);
        err_clr = 1'b0; start = 1'b0;
        exp_ill = 1'b1; exp_ovl = 1'b0; exp_tmo = 1'b0;
        check("clr_vs_set_ready", 64'(ready), 64'd1);
        check("clr_vs_set_result", 64'(result), 64'(QNAN));
        check_flags("clr_vs_set");
        @(negedge clk);

        // Back-to-back: second start presented in the RESP cycle
        start = 1'b1; op = 3'd0; a = 32'h0000_0001; b = 32'h0000_0002; exec_result = 32'hAAAA_0001;
        n_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready) n_rdy++;
            if (k == 1) check("b2b_first_result", 64'(result), 64'h0000_0000_AAAA_0001);
            if (k == 2) begin
                check("b2b_req", 64'(exec_req), 64'd1);
                check("b2b_op", 64'(exec_op), 64'd2);
            end
            start       = (k == 1);
            op          = 3'd2;
            exec_gnt    = (k == 0) || (k == 2);
            exec_done   = (k == 0) || (k == 2);
            exec_result = (k < 2) ? 32'hAAAA_0001 : 32'hBBBB_0002;
        end
        start = 1'b0; exec_gnt = 1'b0; exec_done = 1'b0;
        check("b2b_ready_count", 64'(n_rdy), 64'd2);
        check("b2b_second_result", 64'(result), 64'h0000_0000_BBBB_0002);

        // Asynchronous reset in WAIT
        start = 1'b1; op = 3'd3; a = 32'h4000_0000; b = 32'h4080_0000;
        @(negedge clk);
        start = 1'b0; exec_gnt = 1'b1;
        @(negedge clk);
        exec_gnt = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_overlap", 64'(err_overlap), 64'd1);
        #2 rst = 1'b0;
        #1;
        exp_ill = 1'b0; exp_ovl = 1'b0; exp_tmo = 1'b0;
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_req", 64'(exec_req), 64'd0);
        check("async_rst_result", 64'(result), 64'd0);
        check_flags("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(3'd2, 32'h4040_0000, 32'h4040_0000, 2'd0, 0, 1, 32'h4110_0000, -1);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            g   = $urandom_range(0, 5);
            d   = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) d = 9;
            if (rop > 3'd4) lat = 1;
            else if (1 + g + d <= T) lat = g + d + 2;
            else lat = T + 1;
            ovl_e = -1;
            if (rop <= 3'd4 && $urandom_range(0, 3) == 0) ovl_e = $urandom_range(1, lat - 1);
            run_cmd(rop, $urandom, $urandom, 2'($urandom_range(0, 3)), g, d, $urandom, ovl_e);
            if ($urandom_range(0, 4) == 0) begin
                clear_errs();
                check_flags("rand_clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
